// File: rtl/denise_bpl_serializer.sv
// Denise bitplane serializer: captures BPLxDAT words, applies the BPLCON1
// odd/even scroll delay, and shifts one bit per plane per pixel slot.
// The registered per-pixel plane vector feeds playfield priority and the
// colour table.
module denise_bpl_serializer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk7_en,
    input  logic [8:1]  reg_address_in,
    input  logic [15:0] data_in,
    input  logic        hires,
    input  logic        shres,
    input  logic [2:0]  bpu,
    input  logic        line_start,
    output logic [5:0]  select
);

    localparam logic [8:0] BPL1DAT = 9'h110;
    localparam logic [8:0] BPLCON1 = 9'h102;

    logic [15:0] holding [6];
    logic [15:0] shifter [6];
    logic [7:0]  scroll;
    logic [1:0]  phase;
    logic [3:0]  dly_odd;
    logic [3:0]  dly_even;
    logic        pend_odd;
    logic        pend_even;

    logic [5:0]  wr_dat;
    logic        wr_con1;
    logic        lores_slot;
    logic        pix_slot;
    logic        load_odd;
    logic        load_even;
    logic [5:0]  group_load;
    logic [2:0]  bpu_eff;
    logic [5:0]  select_next;

    // Register write decode; planes 1..6 sit at consecutive word addresses.
    always_comb begin
        wr_con1 = clk7_en && (reg_address_in == BPLCON1[8:1]);
        wr_dat  = 6'd0;
        for (int n = 0; n < 6; n++) begin
            wr_dat[n] = clk7_en && (reg_address_in == (BPL1DAT[8:1] + 8'(n)));
        end
    end

    // Pixel slot timing and group load decision. A BPL1DAT write or
    // line_start in the same clk suppresses any load that would fire.
    always_comb begin
        lores_slot = (phase == 2'd3);
        pix_slot   = shres | (hires ? phase[0] : lores_slot);
        load_odd   = lores_slot && pend_odd  && (dly_odd  == 4'd0) && !wr_dat[0] && !line_start;
        load_even  = lores_slot && pend_even && (dly_even == 4'd0) && !wr_dat[0] && !line_start;
        group_load = 6'd0;
        for (int n = 0; n < 6; n++) begin
            group_load[n] = (n % 2 == 0) ? load_odd : load_even;
        end
    end

    // Plane enable mask; bpu=7 behaves like 6.
    always_comb begin
        bpu_eff     = (bpu == 3'd7) ? 3'd6 : bpu;
        select_next = 6'd0;
        for (int n = 0; n < 6; n++) begin
            select_next[n] = shifter[n][15] & (3'(n) < bpu_eff);
        end
    end

    // Holding registers and scroll register; retained across line_start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < 6; n++) begin
                holding[n] <= 16'd0;
            end
            scroll <= 8'd0;
        end else begin
            for (int n = 0; n < 6; n++) begin
                if (wr_dat[n]) begin
                    holding[n] <= data_in;
                end
            end
            if (wr_con1) begin
                scroll <= data_in[7:0];
            end
        end
    end

    // Pixel phase counter, realigned at the start of each line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= 2'd0;
        end else if (line_start) begin
            phase <= 2'd0;
        end else begin
            phase <= phase + 2'd1;
        end
    end

    // Scroll delay counters. A BPL1DAT write restarts both groups from the
    // pre-write scroll value and wins over a simultaneous line_start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_odd  <= 1'b0;
            pend_even <= 1'b0;
            dly_odd   <= 4'd0;
            dly_even  <= 4'd0;
        end else if (wr_dat[0]) begin
            pend_odd  <= 1'b1;
            pend_even <= 1'b1;
            dly_odd   <= scroll[3:0];
            dly_even  <= scroll[7:4];
        end else if (line_start) begin
            pend_odd  <= 1'b0;
            pend_even <= 1'b0;
            dly_odd   <= 4'd0;
            dly_even  <= 4'd0;
        end else if (lores_slot) begin
            if (pend_odd) begin
                if (dly_odd == 4'd0) begin
                    pend_odd <= 1'b0;
                end else begin
                    dly_odd <= dly_odd - 4'd1;
                end
            end
            if (pend_even) begin
                if (dly_even == 4'd0) begin
                    pend_even <= 1'b0;
                end else begin
                    dly_even <= dly_even - 4'd1;
                end
            end
        end
    end

    // Plane shifters: load beats shift so the loaded MSB is presented first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < 6; n++) begin
                shifter[n] <= 16'd0;
            end
        end else begin
            for (int n = 0; n < 6; n++) begin
                if (line_start) begin
                    shifter[n] <= 16'd0;
                end else if (group_load[n]) begin
                    shifter[n] <= holding[n];
                end else if (pix_slot) begin
                    shifter[n] <= {shifter[n][14:0], 1'b0};
                end
            end
        end
    end

    // Registered plane vector output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            select <= 6'd0;
        end else begin
            select <= select_next;
        end
    end

endmodule

// File: tb/tb_denise_bpl_serializer.sv
module tb_denise_bpl_serializer;

    logic        clk;
    logic        reset;
    logic        clk7_en;
    logic [8:1]  reg_address_in;
    logic [15:0] data_in;
    logic        hires;
    logic        shres;
    logic [2:0]  bpu;
    logic        line_start;
    logic [5:0]  select;

    int n_checks = 0;
    int n_fail   = 0;

    denise_bpl_serializer dut (
        .clk            (clk),
        .reset          (reset),
        .clk7_en        (clk7_en),
        .reg_address_in (reg_address_in),
        .data_in        (data_in),
        .hires          (hires),
        .shres          (shres),
        .bpu            (bpu),
        .line_start     (line_start),
        .select         (select)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Each plane holds the loaded word and a count of pixels already emitted;
    // the visible bit is word bit (15 - emitted), zero once 16 have gone out.
    logic [15:0] m_hold [6];
    logic [15:0] m_word [6];
    int          m_pos  [6];
    logic [7:0]  m_scroll;
    int          m_phase;
    bit          m_pend_odd, m_pend_even;
    int          m_wait_odd, m_wait_even;
    logic [5:0]  exp_q [$];

    initial begin
        for (int n = 0; n < 6; n++) begin
            m_hold[n] = 16'd0;
            m_word[n] = 16'd0;
            m_pos[n]  = 16;
        end
        m_scroll = 8'd0;
        m_phase = 0;
        m_pend_odd = 0; m_pend_even = 0;
        m_wait_odd = 0; m_wait_even = 0;
    end

    always @(posedge clk) begin : model
        logic [5:0] e;
        int  beff;
        int  aidx;
        bit  lores, pix, wr1, wrc, ld_odd, ld_even, ld;
        if (reset) begin
            exp_q.push_back(6'd0);
            for (int n = 0; n < 6; n++) begin
                m_hold[n] = 16'd0;
                m_word[n] = 16'd0;
                m_pos[n]  = 16;
            end
            m_scroll = 8'd0;
            m_phase = 0;
            m_pend_odd = 0; m_pend_even = 0;
            m_wait_odd = 0; m_wait_even = 0;
        end else begin
            beff = (bpu == 3'd7) ? 6 : int'(bpu);
            e = 6'd0;
            for (int n = 0; n < 6; n++) begin
                if (n < beff && m_pos[n] < 16) e[n] = m_word[n][15 - m_pos[n]];
            end
            exp_q.push_back(e);

            lores = (m_phase == 3);
            pix   = shres ? 1'b1 : (hires ? (m_phase % 2 == 1) : lores);
            aidx  = int'(reg_address_in) - 'h88;
            wr1   = clk7_en && (reg_address_in == 8'h88);
            wrc   = clk7_en && (reg_address_in == 8'h81);
            ld_odd  = !wr1 && !line_start && lores && m_pend_odd  && (m_wait_odd  == 0);
            ld_even = !wr1 && !line_start && lores && m_pend_even && (m_wait_even == 0);

            for (int n = 0; n < 6; n++) begin
                ld = (n % 2 == 0) ? ld_odd : ld_even;
                if (line_start) m_pos[n] = 16;
                else if (ld) begin
                    m_word[n] = m_hold[n];
                    m_pos[n]  = 0;
                end else if (pix && m_pos[n] < 16) m_pos[n] = m_pos[n] + 1;
            end

            if (clk7_en && aidx >= 0 && aidx < 6) m_hold[aidx] = data_in;

            if (wr1) begin
                m_pend_odd = 1; m_pend_even = 1;
                m_wait_odd  = int'(m_scroll[3:0]);
                m_wait_even = int'(m_scroll[7:4]);
            end else if (line_start) begin
                m_pend_odd = 0; m_pend_even = 0;
                m_wait_odd = 0; m_wait_even = 0;
            end else if (lores) begin
                if (m_pend_odd) begin
                    if (m_wait_odd == 0) m_pend_odd = 0;
                    else m_wait_odd = m_wait_odd - 1;
                end
                if (m_pend_even) begin
                    if (m_wait_even == 0) m_pend_even = 0;
                    else m_wait_even = m_wait_even - 1;
                end
            end

            if (wrc) m_scroll = data_in[7:0];
            m_phase = line_start ? 0 : (m_phase + 1) % 4;
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin : monitor
        logic [5:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (select !== e) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t select=%b expected=%b", $time, select, e);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        clk7_en = 1'b1;
        reg_address_in = a;
        data_in = d;
        @(negedge clk);
        clk7_en = 1'b0;
    endtask

    task automatic pulse_line();
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
    endtask

    task automatic observe(input int ncyc, input logic [5:0] mask, input logic [5:0] val,
                           output int cnt, output int first, output int last);
        cnt = 0; first = -1; last = -1;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if ((select & mask) == val) begin
                cnt++;
                if (first < 0) first = i;
                last = i;
            end
        end
    endtask

    initial begin : stim
        int cnt, first, last, t0, t1, guard, r;
        clk7_en = 0; reg_address_in = 8'h00; data_in = 16'h0000;
        hires = 0; shres = 0; bpu = 3'd0; line_start = 0;
        reset = 0;
        #1 reset = 1;
        #2 check("reset_select", int'(select), 0);
        @(negedge clk); @(negedge clk);
        reset = 0;
        @(negedge clk);

        // lores, 1 plane, 8001 written at phase 0
        bpu = 3'd1;
        wr(8'h81, 16'h0000);
        pulse_line();
        guard = 0;
        while (m_phase != 0 && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        wr(8'h88, 16'h8001);
        observe(90, 6'h01, 6'h01, cnt, first, last);
        check("lores_ones", cnt, 8);
        check("lores_span", last - first, 63);

        // hires, plane 2 all ones
        hires = 1; bpu = 3'd2;
        wr(8'h89, 16'hFFFF);
        wr(8'h88, 16'h0000);
        observe(80, 6'h3F, 6'h02, cnt, first, last);
        check("hires_cycles", cnt, 32);

        // even-field scroll of 3 lores pixels
        hires = 0;
        wr(8'h81, 16'h0030);
        wr(8'h89, 16'h8000);
        wr(8'h88, 16'h8000);
        t0 = -1; t1 = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (select[0] && t0 < 0) t0 = i;
            if (select[1] && t1 < 0) t1 = i;
        end
        check("scroll_odd_seen", (t0 >= 0) ? 1 : 0, 1);
        check("scroll_delta", t1 - t0, 12);

        // bpu masking
        wr(8'h81, 16'h0000);
        bpu = 3'd3;
        for (int p = 1; p < 6; p++) wr(8'(8'h88 + p), 16'hFFFF);
        wr(8'h88, 16'hFFFF);
        observe(100, 6'h3F, 6'h07, cnt, first, last);
        check("bpu_mask", cnt, 64);

        // line_start during a pending scroll=15 delay
        wr(8'h81, 16'h00FF);
        wr(8'h88, 16'hFFFF);
        observe(8, 6'h3F, 6'h00, cnt, first, last);
        pulse_line();
        observe(120, 6'h3F, 6'h00, cnt, first, last);
        check("line_kill", cnt, 120);

        // BPL1DAT write on the same clk as line_start
        wr(8'h81, 16'h0000);
        line_start = 1'b1;
        wr(8'h88, 16'hFFFF);
        line_start = 1'b0;
        observe(100, 6'h3F, 6'h07, cnt, first, last);
        check("line_same_clk", cnt, 64);

        // async reset while shifting AAAA
        bpu = 3'd1;
        wr(8'h88, 16'hAAAA);
        observe(13, 6'h00, 6'h00, cnt, first, last);
        #2 reset = 1;
        #1 check("reset_async", int'(select), 0);
        @(negedge clk); @(negedge clk);
        reset = 0;
        observe(80, 6'h3F, 6'h00, cnt, first, last);
        check("reset_quiet", cnt, 80);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            clk7_en = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 8);
            if (r < 6) reg_address_in = 8'(8'h88 + r);
            else if (r == 6) reg_address_in = 8'h81;
            else if (r == 7) reg_address_in = 8'h80;
            else reg_address_in = 8'($urandom_range(0, 255));
            data_in = 16'($urandom);
            if (r == 6 && $urandom_range(0, 1) == 0) data_in = 16'($urandom_range(0, 3) * 17);
            line_start = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 63) == 0) {hires, shres} = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 63) == 0) bpu = 3'($urandom_range(0, 7));
            @(negedge clk);
        end
        clk7_en = 0; line_start = 0;
        @(negedge clk); @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
